serial_adder_fsm: RTL and testbench

- Bit-serial ripple adder: the addition counterpart to the team's subtractor blocks.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Adds LSB-first, one bit per clock, using a single full-adder cell.
- Returns sum and carry-out through a second valid/ready handshake. Used where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/full_adder_bit.sv | 16 +
 rtl/serial_adder_fsm.sv | 145 ++++++++++++++
 tb/tb_serial_adder_fsm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    // Controller states; encoding fixed so it reads the same in waveforms.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit-counter width for a given operand width (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full-adder cell used once by the serial datapath.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is parity; carry is the majority of the three inputs.
    always_comb begin
        s  = x ^ y ^ ci;
        co = (x & y) | (x & ci) | (y & ci);
    end

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial ripple adder: {cout, sum} = a + b + cin, one bit per clock, LSB first.
// Optional SERIAL_ADDER_OVF_EN adds a signed-overflow output (ovf).
module serial_adder_fsm
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned      CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_d;
    logic               cout_d;
    logic               in_ready_d;
    logic               out_valid_d;
    logic               fa_s;
    logic               fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_d;
`endif

    // One shared full-adder cell fed by the operand LSBs and the carry flop.
    full_adder_bit u_fa (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state and next-datapath values.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum;
        cout_d  = cout;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sum_d   = {fa_s, sum[WIDTH-1:1]};
                carry_d = fa_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this final step.
                    ovf_d   = carry_q ^ fa_co;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum       <= sum_d;
            cout      <= cout_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed-overflow flag, valid alongside out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm: directed cases plus random operands
// checked against a plain-arithmetic reference. Honors SERIAL_ADDER_OVF_EN.
module tb_serial_adder_fsm;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full operation: accept, count latency, optional backpressure, output handshake.
    task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic cin_i, input int hold, input bit junk, input bit tied);
        logic [W:0]   full;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        int           n;

        full     = {1'b0, a_i} + {1'b0, b_i} + (W+1)'(cin_i);
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        exp_ovf  = (a_i[W-1] == b_i[W-1]) && (exp_sum[W-1] != a_i[W-1]);

        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("in_ready_idle", 64'(in_ready), 64'(1));

        in_valid = 1'b1;
        a        = a_i;
        b        = b_i;
        cin      = cin_i;
        @(posedge clk);
        @(negedge clk);
        if (junk) begin
            a   = W'(8'h11);
            b   = W'(8'h11);
            cin = 1'b1;
        end else begin
            in_valid = 1'b0;
        end

        n = 0;
        while (!out_valid && n < 4 * W) begin
            check_eq("in_ready_busy", 64'(in_ready), 64'(0));
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check_eq("latency", 64'(n), 64'(W));

        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", 64'(out_valid), 64'(1));
            check_eq("hold_sum", 64'(sum), 64'(exp_sum));
            check_eq("hold_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end

        in_valid = 1'b0;
        check_eq("out_valid", 64'(out_valid), 64'(1));
        check_eq("sum", 64'(sum), 64'(exp_sum));
        check_eq("cout", 64'(cout), 64'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("ovf", 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf) begin
            // Overflow case exists in the stimulus but the port is compiled out.
        end
`endif
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!tied) out_ready = 1'b0;
        check_eq("exit_out_valid", 64'(out_valid), 64'(0));
        check_eq("exit_in_ready", 64'(in_ready), 64'(1));
        check_eq("exit_sum_kept", 64'(sum), 64'(exp_sum));
        check_eq("exit_cout_kept", 64'(cout), 64'(exp_cout));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #12;
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_sum", 64'(sum), 64'(0));
        check_eq("rst_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("rst_ovf", 64'(ovf), 64'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b0);
        // Backpressure with ignored operands during SHIFT/DONE.
        run_op(8'h33, 8'h44, 1'b1, 5, 1'b1, 1'b0);

        // Reset in the middle of SHIFT.
        in_valid = 1'b1;
        a        = 8'hC3;
        b        = 8'h5A;
        cin      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 64'(in_ready), 64'(1));
        check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
        check_eq("midrst_sum", 64'(sum), 64'(0));
        check_eq("midrst_cout", 64'(cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        check_eq("midrst_no_valid", 64'(out_valid), 64'(0));
        run_op(8'h0F, 8'h01, 1'b0, 0, 1'b0, 1'b0);

        // Back-to-back with out_ready held high.
        out_ready = 1'b1;
        run_op(8'h01, 8'h02, 1'b0, 0, 1'b0, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 0, 1'b0, 1'b1);
        run_op(8'hAA, 8'h55, 1'b0, 0, 1'b0, 1'b1);
        out_ready = 1'b0;

        // Signed-overflow corner cases.
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        run_op(8'h80, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
        run_op(8'h10, 8'h10, 1'b0, 0, 1'b0, 1'b0);

        // Random operands, backpressure and junk input.
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
